// File: rtl/fifo_arb_pkg.sv
// Shared configuration and types for the FIFO write arbiter.
// Holds the default sizing, the derived index/counter widths and the
// vector typedefs used by the arbiter and its environment.
package fifo_arb_pkg;

  // Width of an index that can address n items (at least one bit).
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int N_REQ = 4;
  localparam int WIDTH = 32;
  localparam int DEPTH = 8;
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int ID_W  = id_width(N_REQ);

  typedef logic [N_REQ-1:0] req_vec_t;
  typedef logic [ID_W-1:0]  grant_id_t;
  typedef logic [CNT_W-1:0] level_t;

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// rr_pick: combinational round-robin selector.
// Searches req starting one position after 'last', wrapping around, and
// returns the first requester found as a one-hot grant plus its index.
// With en low the grant is all zero.
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int N_REQ = fifo_arb_pkg::N_REQ,
  parameter int ID_W  = id_width(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  last,
  input  logic             en,
  output logic [N_REQ-1:0] grant,
  output logic [ID_W-1:0]  win
);

  // Rotating priority search: the candidate after 'last' is examined first.
  always_comb begin
    logic [ID_W-1:0] idx;
    logic            found;
    // NOTE: every combinational output gets a default before any branch so
    // no path leaves it unassigned, which would otherwise infer a latch.
    grant = '0;
    win   = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = ID_W'((int'(last) + 1 + i) % N_REQ);
      if (en && !found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        win        = idx;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin arbiter sharing one FIFO write port among
// N_REQ req/ack producers. The chosen word is registered onto fifo_write /
// fifo_data one cycle after its ack. A reserved-occupancy counter (level)
// counts in-flight writes so the FIFO is never overrun.
// Optional build macro FIFO_WR_ARB_HIPRI_EN: requester 0 becomes strict
// high priority; requesters 1..N_REQ-1 rotate among themselves.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int N_REQ = fifo_arb_pkg::N_REQ,
  parameter int WIDTH = fifo_arb_pkg::WIDTH,
  parameter int DEPTH = fifo_arb_pkg::DEPTH,
  parameter int CNT_W = $clog2(DEPTH) + 1,
  localparam int ID_W = id_width(N_REQ)
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] req_data,
  output logic [N_REQ-1:0]       ack,
  input  logic                   fifo_read_obs,
  input  logic                   fifo_empty,
  input  logic                   fifo_full,
  output logic                   fifo_write,
  output logic [WIDTH-1:0]       fifo_data,
  output logic [ID_W-1:0]        grant_id,
  output logic [CNT_W-1:0]       level
);

  localparam logic [CNT_W-1:0] DEPTH_L = CNT_W'(DEPTH);

  logic [ID_W-1:0]  last;
  logic             slot_ok;
  logic             pick_en;
  logic             hi_win;
  logic [N_REQ-1:0] rr_req;
  logic             rr_en;
  logic [N_REQ-1:0] rr_grant;
  logic [ID_W-1:0]  rr_win;
  logic [ID_W-1:0]  win;
  logic [WIDTH-1:0] win_data;
  logic             any_ack;
  logic             ptr_upd;
  logic             rd_eff;
  logic             dec;
  logic [CNT_W-1:0] level_next;

  // A slot exists only while reserved occupancy is below DEPTH and the FIFO
  // itself does not report full; ack is held off entirely during reset.
  assign slot_ok = (level < DEPTH_L) && !fifo_full;
  assign pick_en = slot_ok && reset;

`ifdef FIFO_WR_ARB_HIPRI_EN
  // Requester 0 bypasses the rotation and is removed from the rotating set.
  assign hi_win = pick_en && req[0];
  assign rr_req = req & ~N_REQ'(1);
  assign rr_en  = pick_en && !hi_win;
`else
  assign hi_win = 1'b0;
  assign rr_req = req;
  assign rr_en  = pick_en;
`endif

  rr_pick #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_rr_pick (
    .req   (rr_req),
    .last  (last),
    .en    (rr_en),
    .grant (rr_grant),
    .win   (rr_win)
  );

  assign ack      = hi_win ? N_REQ'(1) : rr_grant;
  assign win      = hi_win ? '0 : rr_win;
  assign any_ack  = |ack;
  assign ptr_upd  = any_ack && !hi_win;
  assign win_data = req_data[win*WIDTH +: WIDTH];

  // A read of an empty FIFO does not free a slot; the counter never wraps below 0.
  assign rd_eff = fifo_read_obs && !fifo_empty;
  assign dec    = rd_eff && (level != '0);

  // Occupancy bookkeeping: +1 per grant, -1 per effective read, both cancel.
  always_comb begin
    level_next = level;
    if (any_ack && !dec) begin
      level_next = level + CNT_W'(1);
    end else if (!any_ack && dec) begin
      level_next = level - CNT_W'(1);
    end
  end

  // Output stage, round-robin pointer and occupancy counter.
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!reset) begin
      fifo_write <= 1'b0;
      fifo_data  <= '0;
      grant_id   <= '0;
      last       <= ID_W'(N_REQ - 1);
      level      <= '0;
    end else begin
      fifo_write <= any_ack;
      if (any_ack) begin
        fifo_data <= win_data;
        grant_id  <= win;
      end
      if (ptr_upd) begin
        last <= win;
      end
      level <= level_next;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter. A reference model predicts ack
// and level every cycle; each predicted transfer is queued on a scoreboard
// and popped when the registered write is expected on the FIFO side.
module tb_fifo_wr_arbiter;
  import fifo_arb_pkg::*;

  typedef struct packed {
    grant_id_t        id;
    logic [WIDTH-1:0] data;
  } sb_item_t;

  logic                   clock = 1'b0;
  logic                   reset;
  req_vec_t               req;
  logic [N_REQ*WIDTH-1:0] req_data;
  req_vec_t               ack;
  logic                   fifo_read_obs;
  logic                   fifo_empty;
  logic                   fifo_full;
  logic                   fifo_write;
  logic [WIDTH-1:0]       fifo_data;
  grant_id_t              grant_id;
  level_t                 level;

  int n_checks = 0;
  int n_pass   = 0;

  int               m_level;
  int               m_last;
  int               m_win;
  bit               m_pend;
  logic [WIDTH-1:0] m_data;
  int               m_id;
  int               sent [N_REQ];
  sb_item_t         sb [$];

  fifo_wr_arbiter dut (
    .clock         (clock),
    .reset         (reset),
    .req           (req),
    .req_data      (req_data),
    .ack           (ack),
    .fifo_read_obs (fifo_read_obs),
    .fifo_empty    (fifo_empty),
    .fifo_full     (fifo_full),
    .fifo_write    (fifo_write),
    .fifo_data     (fifo_data),
    .grant_id      (grant_id),
    .level         (level)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
  endtask

  // Word requester i offers for its next transfer.
  function automatic logic [WIDTH-1:0] word(input int i);
    logic [WIDTH-1:0] base;
    base = (i == 2) ? 32'hA5A5_0001 : 32'(32'hC000_0000 + (i << 24));
    return base + WIDTH'(sent[i]);
  endfunction

  // Reference arbitration: -1 when nobody is granted.
  function automatic int model_pick(input req_vec_t r, input int last, input bit ok);
    if (!ok) return -1;
`ifdef FIFO_WR_ARB_HIPRI_EN
    if (r[0]) return 0;
`endif
    for (int k = 1; k <= N_REQ; k++) begin
      int j;
      j = (last + k) % N_REQ;
`ifdef FIFO_WR_ARB_HIPRI_EN
      if (j == 0) continue;
`endif
      if (r[j]) return j;
    end
    return -1;
  endfunction

  task automatic drive_data();
    for (int i = 0; i < N_REQ; i++) req_data[i*WIDTH +: WIDTH] = word(i);
  endtask

  // Mid-cycle: predict this cycle's ack and compare all outputs.
  task automatic sample();
    req_vec_t exp_ack;
    sb_item_t it;
    @(negedge clock);
    m_win = model_pick(req, m_last, reset && (m_level < DEPTH) && !fifo_full);
    exp_ack = '0;
    if (m_win >= 0) exp_ack[m_win] = 1'b1;
    check("ack", ack, exp_ack);
    check("level", level, m_level);
    check("fifo_write", fifo_write, m_pend);
    if (m_pend) begin
      it = sb.pop_front();
      m_data = it.data;
      m_id = it.id;
    end
    check("fifo_data", fifo_data, m_data);
    check("grant_id", grant_id, m_id);
  endtask

  // Clock edge: advance the model, then present the next words.
  task automatic advance();
    @(posedge clock);
    if (!reset) begin
      m_level = 0;
      m_last  = N_REQ - 1;
      m_pend  = 1'b0;
      m_data  = '0;
      m_id    = 0;
      sb.delete();
    end else begin
      int old_level;
      old_level = m_level;
      m_pend = (m_win >= 0);
      if (m_win >= 0) begin
        sb.push_back('{id: grant_id_t'(m_win), data: word(m_win)});
        sent[m_win]++;
`ifdef FIFO_WR_ARB_HIPRI_EN
        if (m_win != 0) m_last = m_win;
`else
        m_last = m_win;
`endif
        m_level++;
      end
      if (fifo_read_obs && !fifo_empty && old_level != 0) m_level--;
    end
    #1;
    drive_data();
  endtask

  task automatic reset_pulse();
    reset = 1'b0;
    sample();
    advance();
    reset = 1'b1;
  endtask

  function automatic req_vec_t exp_rr(input int k);
    if (k >= DEPTH) return '0;
`ifdef FIFO_WR_ARB_HIPRI_EN
    return req_vec_t'(1);
`else
    return req_vec_t'(1 << (k % N_REQ));
`endif
  endfunction

  function automatic req_vec_t exp_fair(input int k);
`ifdef FIFO_WR_ARB_HIPRI_EN
    return req_vec_t'(1);
`else
    return (k % 2 == 0) ? req_vec_t'(1) : req_vec_t'(2);
`endif
  endfunction

  initial begin
    reset = 1'b0;
    req = '1;
    fifo_read_obs = 1'b0;
    fifo_empty = 1'b1;
    fifo_full = 1'b0;
    for (int i = 0; i < N_REQ; i++) sent[i] = 0;
    m_level = 0; m_last = N_REQ - 1; m_win = -1; m_pend = 1'b0; m_data = '0; m_id = 0;
    drive_data();
    @(posedge clock);
    #1;

    // Reset held with every requester asserting.
    repeat (2) begin
      sample();
      check("rst_ack", ack, 4'b0000);
      check("rst_wr", fifo_write, 1'b0);
      check("rst_lvl", level, 0);
      advance();
    end
    reset = 1'b1;
    sample();
    check("first_ack", ack, 4'b0001);
    advance();

    // Reset while a word is in flight: the word shows, then is discarded.
    reset = 1'b0;
    sample();
    check("inflight_wr", fifo_write, 1'b1);
    advance();
    reset = 1'b1;

    // Single requester, three successive words.
    req = 4'b0100;
    sample(); check("single_ack0", ack, 4'b0100); check("single_wr0", fifo_write, 1'b0); advance();
    sample(); check("single_ack1", ack, 4'b0100); check("single_d1", fifo_data, 32'hA5A5_0001); advance();
    sample(); check("single_ack2", ack, 4'b0100); check("single_d2", fifo_data, 32'hA5A5_0002); advance();
    req = '0;
    sample();
    check("single_ack3", ack, 4'b0000);
    check("single_d3", fifo_data, 32'hA5A5_0003);
    check("single_id", grant_id, 2);
    check("single_lvl", level, 3);
    advance();

    // All four requesting, no reads: rotation then stall at DEPTH.
    reset_pulse();
    req = '1;
    for (int k = 0; k < DEPTH + 2; k++) begin
      sample();
      check("rr_ack", ack, exp_rr(k));
      advance();
    end

    // Full, then one effective read frees exactly one slot.
    fifo_read_obs = 1'b1;
    fifo_empty = 1'b0;
    sample(); check("full_noack", ack, 4'b0000); check("full_lvl", level, 8); check("full_wr", fifo_write, 1'b0); advance();
    fifo_read_obs = 1'b0;
    sample(); check("refill_ack", ack, 4'b0001); check("refill_lvl", level, 7); advance();
    sample(); check("refull_lvl", level, 8); check("refull_ack", ack, 4'b0000); advance();

    // Drain to 5, then grant and read together hold the level.
    req = '0;
    fifo_read_obs = 1'b1;
    repeat (3) begin sample(); advance(); end
    req = 4'b0010;
    sample(); check("gr_rd_ack", ack, 4'b0010); check("gr_rd_lvl0", level, 5); advance();
    req = '0;
    sample(); check("gr_rd_lvl1", level, 5); advance();
    repeat (4) begin sample(); advance(); end

    // Reads while empty are ignored.
    fifo_empty = 1'b1;
    repeat (2) begin
      sample();
      check("empty_rd_lvl", level, 0);
      check("empty_rd_ack", ack, 4'b0000);
      advance();
    end

    // FIFO full flag blocks grants even with reserved room.
    fifo_read_obs = 1'b0;
    fifo_empty = 1'b0;
    fifo_full = 1'b1;
    req = '1;
    sample(); check("fullflag_ack", ack, 4'b0000); advance();
    fifo_full = 1'b0;
    req = '0;
    fifo_empty = 1'b1;

    // Two requesters held continuously.
    reset_pulse();
    req = 4'b0011;
    for (int k = 0; k < 6; k++) begin
      sample();
      check("fair_ack", ack, exp_fair(k));
      advance();
    end

    // Randomised traffic checked against the model.
    reset_pulse();
    for (int k = 0; k < 300; k++) begin
      req = req_vec_t'($urandom_range(0, (1 << N_REQ) - 1));
      fifo_read_obs = 1'($urandom_range(0, 1));
      fifo_empty = (m_level == 0);
      fifo_full = ($urandom_range(0, 15) == 0);
      sample();
      advance();
    end
    req = '0;
    fifo_read_obs = 1'b0;
    fifo_full = 1'b0;
    repeat (2) begin sample(); advance(); end
    check("sb_drain", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Round-robin write arbiter that shares one synchronous FIFO write port among N_REQ producers.
- Each producer uses a req/ack handshake. The arbiter drives the FIFO's write and data_in from a registered stage.
- The arbiter keeps its own reserved-occupancy count, so it never overruns the FIFO, even with the one-cycle write pipeline.
- Sits between the producer blocks and the fifo instance; the consumer's read strobe is tapped into the arbiter.

Parameters:
- N_REQ, 4, number of requesters (2..8)
- WIDTH, 32, data word width; matches the FIFO width
- DEPTH, 8, FIFO depth in words
- CNT_W, 4, occupancy counter width, equal to clog2(DEPTH)+1

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  synchronous, active-low reset
- req  in  N_REQ  per-requester write request; held with data until acked
- req_data  in  N_REQ*WIDTH  requester i's word at bits [i*WIDTH +: WIDTH]
- ack  out  N_REQ  one-hot grant, combinational; transfer occurs at the clock edge where req[i]&ack[i]
- fifo_read_obs  in  1  consumer's read strobe to the FIFO
- fifo_empty  in  1  FIFO empty flag
- fifo_full  in  1  FIFO full flag (safety qualifier)
- fifo_write  out  1  registered write strobe to the FIFO
- fifo_data  out  WIDTH  registered data to FIFO data_in
- grant_id  out  clog2(N_REQ)  index of the requester whose word is on fifo_data
- level  out  CNT_W  reserved occupancy, including any in-flight write

Behaviour:
- Reset (reset==0 at a rising edge):
  - fifo_write=0, fifo_data=0, grant_id=0, level=0.
  - Round-robin pointer last=N_REQ-1, so requester 0 has first priority.
  - ack is forced to 0 while reset==0.
- Reset mid-operation discards any in-flight word; the FIFO must be reset in the same cycle.
- Eligibility: slot_ok = (level < DEPTH) && !fifo_full.
- Pick: when slot_ok, search req starting at index (last+1) mod N_REQ, wrapping; the first set bit wins.
  - ack is one-hot at the winner, or all zero when there is no request or !slot_ok.
- Transfer edge (any ack bit set):
  - fifo_write<=1, fifo_data<=req_data[win], grant_id<=win, last<=win.
  - Otherwise fifo_write<=0; fifo_data and grant_id hold their values.
- Latency: a word is on fifo_write/fifo_data exactly 1 cycle after its ack cycle. Throughput is 1 word/cycle.
- Effective read: rd_eff = fifo_read_obs && !fifo_empty.
- Level update: level_next = level + (|ack) - rd_eff.
  - A grant and an effective read in the same cycle leave level unchanged.
- Level never exceeds DEPTH and never underflows. A read while fifo_empty is ignored.
- Level == DEPTH: no grant that cycle, even if rd_eff=1. A grant can occur the next cycle, once level=DEPTH-1.
- The pointer only advances on a grant. Idle cycles do not rotate priority.
- Requester rules: req_data must be stable while req=1. Dropping req before ack is legal; no word is written.

Optional Feature:
- Macro: FIFO_WR_ARB_HIPRI_EN.
- Defined: requester 0 is strict high priority. If req[0] && slot_ok, requester 0 wins regardless of the pointer, and the pointer is not updated. Requesters 1..N_REQ-1 rotate round-robin among themselves.
- Undefined: pure round-robin across all N_REQ requesters.

Decomposition:
- Package fifo_arb_pkg:
  - Constants N_REQ, WIDTH, DEPTH, CNT_W, and ID_W = clog2(N_REQ).
  - Typedefs req_vec_t [N_REQ-1:0], grant_id_t [ID_W-1:0], level_t [CNT_W-1:0].
- One sub-module, rr_pick: combinational rotate / priority-encode / unrotate.
  - Inputs: req, last, en.
  - Outputs: one-hot grant and win index.
- The top module holds the pointer, level counter and output registers.

Test Plan:
- Reset check: reset=0 for 2 cycles with req=4'b1111 -> ack=0, fifo_write=0, level=0. After release, the first ack is 4'b0001.
- Single requester: req[2]=1 with words 0xA5A50001, 0xA5A50002, 0xA5A50003 on successive acks -> ack[2] high 3 consecutive cycles; fifo_write high the following 3 cycles with data in order and grant_id=2; level=3.
- All four requesting continuously, no reads -> grant order 0,1,2,3,0,1,2,3; level reaches 8, then ack=0 and fifo_write=0 while full.
- Full with reads: at level=8, pulse fifo_read_obs=1 with fifo_empty=0 -> level=7. Next cycle one grant goes to requester 0 (pointer continues), level=8. Separately, at level=5 with a grant and rd_eff together -> level stays 5.
- Empty read: level=0, fifo_read_obs=1, fifo_empty=1 -> level stays 0 and no grant without req.
- Fairness and option: req[0] and req[1] held continuously.
  - Without FIFO_WR_ARB_HIPRI_EN -> ack alternates 0,1,0,1.
  - With FIFO_WR_ARB_HIPRI_EN -> ack[0] every cycle until level=DEPTH.
